// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit with a DEPTH-entry prefetch queue.
// Issues sequential word fetches over a req/ack handshake (one outstanding
// request at most), buffers {word, pc+4} and presents the head to decode.
// A redirect flushes the queue and restarts fetching at redirect_pc. A request
// that is already outstanding is never withdrawn; its data is discarded.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_req, mem_addr         fetch request and word-aligned address
//   mem_ack, mem_rdata        memory response handshake and data
//   instr_valid, instr,       queue head (instr/instr_pc_next are 0 when empty)
//   instr_pc_next
//   consume                   decode takes the head this cycle
//   redirect, redirect_pc     flush and refetch from redirect_pc & ~3
//   perf_fetched,             (only with IFU_PERF_EN) accepted-word and
//   perf_dropped              discarded-word event counters
//
// Optional feature macro: IFU_PERF_EN adds the two performance counters.
module ifu_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc_next,
  input  logic        consume,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc_next;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [PW-1:0] rd_ptr, rd_next, wr_ptr, wr_next;
  logic [CW-1:0] count, count_next, remain;
  entry_t        fifo_mem [DEPTH];
  entry_t        push_entry, head_next;
  logic          valid_next, req_next, accept, push, pop;
  logic [31:0]   addr_next;
`ifdef IFU_PERF_EN
  logic [31:0]   drop_inc;
`endif

  // Next-state, queue bookkeeping and next registered outputs
  always_comb begin
    state_next    = state;
    accept        = (state != IDLE) && mem_ack;
    push          = (state == REQ) && mem_ack && !redirect;
    pop           = consume && (count != '0) && !redirect;
    count_next    = count + CW'(push) - CW'(pop);
    remain        = count - CW'(pop);
    rd_next       = rd_ptr + PW'(pop);
    wr_next       = wr_ptr + PW'(push);
    fetch_pc_next = push ? (fetch_pc + 32'd4) : fetch_pc;
    push_entry    = '{word: mem_rdata, pc_next: fetch_pc + 32'd4};
    head_next     = '0;
    valid_next    = 1'b0;

    // Head after this edge: surviving entry, else the word pushed into an empty queue
    if (remain != '0) begin
      head_next  = fifo_mem[rd_next];
      valid_next = 1'b1;
    end else if (push) begin
      head_next  = push_entry;
      valid_next = 1'b1;
    end

    // Requests only issue when a slot is guaranteed for the returning word
    case (state)
      IDLE:    if (count_next < CW'(DEPTH)) state_next = REQ;
      REQ:     if (mem_ack) state_next = (count_next < CW'(DEPTH)) ? REQ : IDLE;
      DROP:    if (mem_ack) state_next = REQ;
      default: state_next = IDLE;
    endcase

    // Redirect overrides push/pop; an unacked outstanding request must drain in DROP
    if (redirect) begin
      count_next    = '0;
      rd_next       = '0;
      wr_next       = '0;
      fetch_pc_next = redirect_pc & ~32'd3;
      head_next     = '0;
      valid_next    = 1'b0;
      state_next    = ((state != IDLE) && !mem_ack) ? DROP : REQ;
    end

    req_next  = (state_next != IDLE);
    // While draining, the old address stays on the bus
    addr_next = (state_next == DROP) ? mem_addr : fetch_pc_next;

`ifdef IFU_PERF_EN
    drop_inc = (redirect ? 32'(count) : 32'd0)
             + 32'((accept && ((state == DROP) || redirect)) ? 1'b1 : 1'b0);
`endif
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= RESET_PC;
      instr_valid   <= 1'b0;
      instr         <= '0;
      instr_pc_next <= '0;
    end else begin
      state         <= state_next;
      fetch_pc      <= fetch_pc_next;
      rd_ptr        <= rd_next;
      wr_ptr        <= wr_next;
      count         <= count_next;
      mem_req       <= req_next;
      mem_addr      <= addr_next;
      instr_valid   <= valid_next;
      instr         <= head_next.word;
      instr_pc_next <= head_next.pc_next;
    end
  end

  // Queue storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr] <= push_entry;
  end

`ifdef IFU_PERF_EN
  // Event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_dropped <= perf_dropped + drop_inc;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized scoreboard bench for ifu_prefetch. A random-latency memory and
// random consume/redirect drive the DUT; a transaction-level model (queue of
// expected {word, pc+4}, next sequential PC, stale-request flag) predicts the
// head, request and address every cycle.
module tb_ifu_prefetch;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst, mem_req, mem_ack, instr_valid, consume, redirect;
  logic [31:0] mem_addr, mem_rdata, instr, instr_pc_next, redirect_pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc_next(instr_pc_next),
    .consume(consume), .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pcn;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc, stale_addr, m_fetched, m_dropped;
  bit          stale, m_req, started, chk_rst_addr;
  int          pops;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compare outputs against the model, then advance the model
  always @(negedge clk) begin
    bit acc;
    exp_t e;
    if (started) begin
      check32("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check32("instr", instr, exp_q[0].word);
        check32("instr_pc_next", instr_pc_next, exp_q[0].pcn);
      end else begin
        check32("instr_empty", instr, 32'd0);
        check32("pc_next_empty", instr_pc_next, 32'd0);
      end
      check32("mem_req", 32'(mem_req), 32'(m_req));
      if (m_req) check32("mem_addr", mem_addr, stale ? stale_addr : m_pc);
      check32("mem_addr_align", 32'(mem_addr[1:0]), 32'd0);
      if (chk_rst_addr) check32("reset_mem_addr", mem_addr, RESET_PC);
`ifdef IFU_PERF_EN
      check32("perf_fetched", perf_fetched, m_fetched);
      check32("perf_dropped", perf_dropped, m_dropped);
`endif
    end

    chk_rst_addr = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_pc         = RESET_PC;
      stale        = 1'b0;
      m_req        = 1'b0;
      m_fetched    = '0;
      m_dropped    = '0;
      started      = 1'b1;
      chk_rst_addr = 1'b1;
    end else if (started) begin
      acc = m_req && mem_ack;
      if (redirect) begin
        m_dropped += 32'(exp_q.size()) + 32'(acc);
        exp_q.delete();
        if (m_req && !acc) begin
          if (!stale) stale_addr = m_pc;
          stale = 1'b1;
        end else begin
          stale = 1'b0;
        end
        m_pc  = redirect_pc & ~32'd3;
        m_req = 1'b1;
      end else begin
        if (consume && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          pops++;
        end
        if (acc) begin
          if (stale) begin
            stale = 1'b0;
            m_dropped += 32'd1;
          end else begin
            e.word = mem_rdata;
            e.pcn  = m_pc + 32'd4;
            exp_q.push_back(e);
            m_pc += 32'd4;
            m_fetched += 32'd1;
          end
        end
        m_req = (m_req && !acc) ? 1'b1 : (exp_q.size() < DEPTH);
      end
    end
  end

  // Stimulus and memory responder
  int lat      = -1;
  int max_lat  = 3;
  int cons_pct = 50;
  int redir_pct = 3;
  int spur_pct = 10;

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFC;
      1:       return 32'h0000_3202;
      2:       return 32'hFFFF_FFF8;
      3:       return 32'h0000_3100;
      default: return $urandom();
    endcase
  endfunction

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    consume     = ($urandom_range(0, 99) < cons_pct);
    redirect    = ($urandom_range(0, 99) < redir_pct);
    redirect_pc = pick_pc();
    mem_rdata   = $urandom();
    if (rst) begin
      lat     = -1;
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (lat < 0) lat = $urandom_range(0, max_lat);
      mem_ack = (lat == 0);
      if (lat == 0) lat = -1;
      else lat--;
    end else begin
      lat     = -1;
      mem_ack = ($urandom_range(0, 99) < spur_pct);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  initial begin
    int p0;
    rst = 1'b1; consume = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    pops = 0; started = 1'b0; stale = 1'b0; m_req = 1'b0;
    m_fetched = '0; m_dropped = '0; m_pc = RESET_PC; stale_addr = '0;
    run(3);
    rst = 1'b0;

    // Mixed traffic
    cons_pct = 50; redir_pct = 3; max_lat = 3;
    run(800);

    // Decode stalled: queue fills, requests stop, occasional single consumes
    cons_pct = 5; redir_pct = 0; max_lat = 0;
    run(400);

    // Streaming: same-cycle acks and continuous consume
    cons_pct = 100; redir_pct = 0; max_lat = 0; spur_pct = 0;
    run(10);
    p0 = pops;
    run(50);
    check32("throughput", 32'(pops - p0 >= 49), 32'd1);

    // Reset in the middle of traffic
    cons_pct = 50; redir_pct = 5; max_lat = 3; spur_pct = 10;
    run(300);
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // Redirect-heavy traffic with long latency
    cons_pct = 60; redir_pct = 25; max_lat = 4;
    run(1500);

    // Random mix
    cons_pct = 70; redir_pct = 4; max_lat = 2;
    run(1500);

    redirect = 1'b0;
    run(2);
    check32("fetch_activity", 32'(m_fetched > 32'd200), 32'd1);
    check32("drop_activity", 32'(m_dropped != 32'd0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
